// File: rtl/mouse_cursor_x_pkg.sv
// Shared constants for the mouse cursor datapath: button bit positions,
// packet delta width and the cursor FSM state encodings.
package mouse_pkg;
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_MID   = 2;

  localparam int PKT_W = 9;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SUM   = 2'd1;
  localparam logic [1:0] CLAMP = 2'd2;
endpackage

// File: rtl/mouse_cursor_x_if.sv
// Decoded PS/2 packet bus: the packet decoder drives it and the cursor block
// consumes it.
interface mouse_cursor_x_if import mouse_pkg::*; ();
  logic [PKT_W-1:0] xm;
  logic [2:0]       btnm;
  logic             m_done_tick;

  modport master (output xm, btnm, m_done_tick);
  modport slave  (input  xm, btnm, m_done_tick);
endinterface

// File: rtl/mouse_sat_clamp.sv
// Saturates a signed W+2 bit cursor sum into the legal range 0..XMAX.
module mouse_sat_clamp #(
  parameter int W    = 10,
  parameter int XMAX = 639
) (
  input  logic signed [W+1:0] i_sum,
  output logic        [W-1:0] o_pos
);
  localparam logic signed [W+1:0] MAXS = (W+2)'(XMAX);

  always_comb begin
    if (i_sum[W+1])
      o_pos = '0;
    else if (i_sum > MAXS)
      o_pos = W'(XMAX);
    else
      o_pos = i_sum[W-1:0];
  end
endmodule

// File: rtl/mouse_cursor_x.sv
// Accumulates PS/2 X deltas into a saturated cursor position and turns
// left/right button presses into one-cycle click pulses.
module mouse_cursor_x import mouse_pkg::*; #(
  parameter int W      = 10,
  parameter int XMAX   = 639,
  parameter int X_INIT = 320,
  parameter int SHIFT  = 0
) (
  input  logic                clk,
  input  logic                rst,
  mouse_cursor_x_if.slave     bus,
  input  logic                center,
  output logic [W-1:0]        cursor_x,
  output logic [2:0]          btn_state,
  output logic                left_click,
  output logic                right_click,
  output logic                upd_tick,
  output logic                overrun
);
  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic signed [W+1:0] r_d;
  logic [2:0]          r_btn;
  logic signed [W+1:0] r_sum;
  logic [W-1:0]        w_base;
  logic signed [W+1:0] w_sum;
  logic [W-1:0]        w_clamped;

  // A center request in SUM must feed the sum, so the packet completes from X_INIT.
  assign w_base = center ? W'(X_INIT) : cursor_x;
  assign w_sum  = $signed({2'b00, w_base}) + (r_d >>> SHIFT);

  mouse_sat_clamp #(.W(W), .XMAX(XMAX)) u_clamp (
    .i_sum (r_sum),
    .o_pos (w_clamped)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.m_done_tick) w_state_nxt = SUM;
      SUM:     w_state_nxt = CLAMP;
      CLAMP:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_d         <= '0;
      r_btn       <= '0;
      r_sum       <= '0;
      cursor_x    <= W'(X_INIT);
      btn_state   <= '0;
      left_click  <= 1'b0;
      right_click <= 1'b0;
      upd_tick    <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      left_click  <= 1'b0;
      right_click <= 1'b0;
      upd_tick    <= 1'b0;
      overrun     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.m_done_tick) begin
            r_d   <= {{(W+2-PKT_W){bus.xm[PKT_W-1]}}, bus.xm};
            r_btn <= bus.btnm;
          end
        end
        SUM: begin
          r_sum <= w_sum;
          if (bus.m_done_tick) overrun <= 1'b1;
        end
        CLAMP: begin
          cursor_x    <= w_clamped;
          btn_state   <= r_btn;
          upd_tick    <= 1'b1;
          left_click  <= r_btn[BTN_LEFT]  & ~btn_state[BTN_LEFT];
          right_click <= r_btn[BTN_RIGHT] & ~btn_state[BTN_RIGHT];
          if (bus.m_done_tick) overrun <= 1'b1;
        end
        default: ;
      endcase
      // Center overrides any clamp write issued in the same cycle.
      if (center) cursor_x <= W'(X_INIT);
    end
  end
endmodule
